alu_nibble_seq: RTL
===================

Name: alu_nibble_seq

Overview:
Nibble-serial ALU sequencer that sits directly upstream of a single alu4 slice, which it instantiates internally. It accepts WIDTH-bit operands plus a 3-bit ALU op, then feeds one 4-bit nibble per cycle through the alu4, LSB nibble first. It registers the inter-nibble carry and assembles the WIDTH-bit result. It also produces N/Z/C/V flags for the execute stage, giving a low-area alternative to a full-width carry-lookahead ALU.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8; NIB = WIDTH/4 nibbles per op.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while ready=1.
A  input  WIDTH  operand A; captured when start is accepted.
B  input  WIDTH  operand B; captured when start is accepted.
ctrl  input  3  op code: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR; captured when start is accepted.
ready  output  1  high only in IDLE.
done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
result  output  WIDTH  assembled result; holds until the next accepted start.
negative  output  1  result[WIDTH-1].
zero  output  1  result == 0.
carry  output  1  final-nibble cOut for ADD/SUB; 0 for all other ops.
overflow  output  1  final-nibble cOut XOR cInMSB for ADD/SUB; 0 for all other ops.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset state: IDLE, ready=1, done=0, result=0, all flags=0, nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: capture A, B, ctrl; set cnt=0; set carry register = ctrl[0]; go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - Each edge processes nibble cnt. alu4 is driven with A[4cnt+3:4cnt], B[4cnt+3:4cnt], cIn = carry register, ctrl = captured ctrl.
  - aluOut is written into result[4cnt+3:4cnt]. The carry register takes cOut, and cnt increments.
  - At the edge processing cnt = NIB-1: write carry and overflow from that nibble's cOut/cInMSB, then go to DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE.
- Latency: with start accepted at E0, done is high during the cycle after edge E(NIB), i.e. NIB cycles after acceptance (4 for WIDTH=16). Throughput is one op per NIB+2 cycles.
- result update rule: result nibbles update progressively during RUN. result is only guaranteed valid when done=1 and afterwards.
- Flag rule: negative and zero are derived from the registered result. They are meaningful only from done onward.
- Captured operands are frozen. Changes to A, B or ctrl after acceptance do not affect the op in flight.
- start while ready=0 (RUN or DONE) is ignored and not queued.
- Reserved ctrl codes 001 and 111 are forced to 000 (PASS_B) at capture.
- SUB carry convention: carry=1 means no borrow (A >= B unsigned).
- Reset asserted mid-RUN or in DONE: the op is aborted on that edge, all state returns to reset values, and no done pulse is produced for the aborted op.
- reset and start high on the same edge: reset wins.

Test Plan:
1. WIDTH=16, ADD A=0x00FF B=0x0001, start for 1 cycle -> ready drops the next cycle; done pulses exactly 4 cycles after acceptance; result=0x0100, N=0 Z=0 C=0 V=0; ready=1 the cycle after done.
2. ADD 0xFFFF+0x0001 -> result=0x0000, Z=1 C=1 V=0 N=0. ADD 0x7FFF+0x0001 -> result=0x8000, N=1 V=1 C=0.
3. SUB 0x0003-0x0005 -> result=0xFFFE, N=1 C=0 V=0. SUB 0x1234-0x1234 -> result=0x0000, Z=1 C=1. SUB 0x8000-0x0001 -> result=0x7FFF, V=1 C=1.
4. Logic ops and PASS_B:
   - AND 0xF0F0,0xFF00 -> 0xF000, N=1 C=0 V=0.
   - OR 0x0A0A,0x5050 -> 0x5A5A.
   - XOR 0xFFFF,0xFFFF -> 0x0000, Z=1.
   - PASS_B A=0x1111 B=0xC3A5 -> 0xC3A5, N=1.
   - ctrl=111 with B=0x0042 -> 0x0042.
5. Start ADD 0x0001+0x0001; pulse start again with different operands, and change A/B, during RUN -> result=0x0002; only one done pulse; second request not executed.
6. Reset asserted two cycles into a RUN -> next cycle state IDLE, ready=1, result=0, flags=0, done never asserts. A following ADD 0x0010+0x0020 completes with result 0x0030.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - nibble-serial ALU sequencer driving one 4-bit alu4 slice
// Operands are captured on start and streamed LSB nibble first; flags register on the last nibble.

module alu4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  input  logic [2:0] ctrl_i,
  output logic [3:0] out_o,
  output logic       c_o,
  output logic       c_msb_o
);
  logic [3:0] b_eff;
  logic [3:0] low_sum;
  logic [4:0] full_sum;

  always_comb begin
    b_eff    = ctrl_i[0] ? ~b_i : b_i;
    // carry into bit 3 is the carry out of the low three bits
    low_sum  = {1'b0, a_i[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, c_i};
    full_sum = {1'b0, a_i} + {1'b0, b_eff} + {4'b0000, c_i};
    out_o    = 4'h0;
    c_o      = 1'b0;
    c_msb_o  = 1'b0;
    case (ctrl_i)
      3'b000: out_o = b_i;
      3'b010, 3'b011: begin
        out_o   = full_sum[3:0];
        c_o     = full_sum[4];
        c_msb_o = low_sum[3];
      end
      3'b100: out_o = a_i & b_i;
      3'b101: out_o = a_i | b_i;
      3'b110: out_o = a_i ^ b_i;
      default: out_o = 4'h0;
    endcase
  end
endmodule

module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ctrl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q;
  logic             cin_q, ready_q, done_q;
  logic             neg_q, zero_q, carry_q, ovf_q;
  logic [CW+1:0]    nib_base;
  logic [3:0]       alu_out;
  logic             alu_c, alu_c_msb, is_arith, last_nib;

  assign nib_base = {cnt_q, 2'b00};
  assign is_arith = (op_q[2:1] == 2'b01);
  assign last_nib = (cnt_q == CW'(NIB - 1));

  alu4 u_alu4 (
    .a_i     (a_q[nib_base +: 4]),
    .b_i     (b_q[nib_base +: 4]),
    .c_i     (cin_q),
    .ctrl_i  (op_q),
    .out_o   (alu_out),
    .c_o     (alu_c),
    .c_msb_o (alu_c_msb)
  );

  always_comb begin
    op_d = ((ctrl == 3'b001) || (ctrl == 3'b111)) ? 3'b000 : ctrl;
    result_d = result_q;
    result_d[nib_base +: 4] = alu_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op_d;
            cin_q   <= op_d[0];
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          result_q <= result_d;
          cin_q    <= alu_c;
          cnt_q    <= cnt_q + 1'b1;
          if (last_nib) begin
            carry_q <= is_arith & alu_c;
            ovf_q   <= is_arith & (alu_c ^ alu_c_msb);
            neg_q   <= result_d[WIDTH-1];
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign negative = neg_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
endmodule
